wr_resp_collect: RTL and testbench
==================================

// Module: wr_resp_collect
// PURPOSE
//  AXI write-response (B channel) master-side receiver for the cache's memory port; far end of
//  the memory slave's B-channel driver. Tracks outstanding writes per AXI ID and accepts bid/bresp.
//  Flags unexpected IDs and error responses.
//  Forwards each completion to the cache write-back logic through a 1-entry output register.
// PARAMETERS
//  ADD_ID_WIDTH  4   AXI ID width; same value as the memory slave's, from the shared header
//  MAX_OUTST     8   max writes in flight across all IDs; CNT_W = clog2(MAX_OUTST+1)
// PORTS
//  clk            in   1             system clock, rising edge
//  reset          in   1             asynchronous, active-high reset
//  aw_issue_valid in   1             cache issued an AW beat this cycle (AW handshake done)
//  aw_issue_id    in   ADD_ID_WIDTH  ID of that write
//  issue_ready    out  1             1 = another write may be issued (total < MAX_OUTST)
//  bid            in   ADD_ID_WIDTH  AXI B-channel ID
//  bresp          in   2             AXI B-channel response
//  bvalid         in   1             AXI B-channel valid
//  bready         out  1             AXI B-channel ready
//  cmpl_valid     out  1             completion available to cache
//  cmpl_id        out  ADD_ID_WIDTH  completed write ID
//  cmpl_resp      out  2             completed write response
//  cmpl_ready     in   1             cache consumes completion
//  all_done       out  1             total outstanding == 0
//  err_flag       out  1             sticky: SLVERR/DECERR seen, or B with no matching outstanding ID
//  err_id         out  ADD_ID_WIDTH  bid of first error; frozen while err_flag = 1
//  err_clr        in   1             clears err_flag and err_id; lower priority than a same-cycle new error
// BEHAVIOUR
//  Reset values: issue_ready=0, bready=0, cmpl_valid=0, cmpl_id=0, cmpl_resp=0,
//   all_done=1, err_flag=0, err_id=0. All counters cleared.
//   A flop rst_done goes 1 the first clk after reset deasserts. Until then, issue_ready=0 and bready=0.
//  bready = rst_done & (!cmpl_valid | cmpl_ready). Combinational pass of cmpl_ready.
//   This gives full throughput: 1 B beat per clock.
//  B handshake = bvalid & bready. On handshake: cmpl_valid<=1, cmpl_id<=bid, cmpl_resp<=bresp.
//   Latency is 1 clock. Without a handshake, cmpl_valid clears when cmpl_ready=1.
//  Counters: cnt[id] (2^ADD_ID_WIDTH x CNT_W) and total (CNT_W).
//   issue increments cnt[aw_issue_id] and total.
//   Handshake with cnt[bid] > 0 decrements cnt[bid] and total.
//   Same cycle, same ID: cnt unchanged. Same cycle, different IDs: both updated. Total is unchanged.
//  issue_ready = rst_done & (total < MAX_OUTST), from registered total only.
//   No same-cycle bypass from a response.
//   aw_issue_valid while issue_ready=0 is a protocol error. The counter saturates at MAX_OUTST.
//  Unexpected ID: handshake with cnt[bid]==0 and no same-cycle issue of that ID.
//   The beat is still accepted and forwarded. Counters are not decremented. err_flag is set.
//  bresp = 2'b10 (SLVERR) or 2'b11 (DECERR): forwarded and counted normally; err_flag is set.
//   OKAY/EXOKAY are not errors.
//  err_id captures bid only when err_flag is 0 (first error wins). err_clr and a new error
//   in the same cycle: the flag stays 1 and err_id is loaded with the new bid.
//  Reset mid-operation: all outstanding state is discarded. A pending completion is dropped.
//  all_done = (total == 0), registered.
// STRUCTURE
//  Shared header: ADD_ID_WIDTH, and BRESP codes RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3.
//   Same header as the memory slave.
//  Sub-module: wr_outst_cnt, the per-ID counter array with an inc/dec port pair, cnt_zero[id], and total.
//  Top level holds: rst_done, bready logic, completion register, error capture.
// TESTING
//  1 Reset, then idle: issue_ready=1 and bready=1 on 2nd clk after deassert, all_done=1.
//  2 Issue IDs 3,3,5; B id=5 OKAY, then id=3, then id=3, cmpl_ready=1 ->
//    cmpl_id 5,3,3 one clk after each handshake. all_done=1 after the last. err_flag=0.
//  3 Issue 8 writes -> issue_ready=0. B id=0 with cmpl_ready=0 -> bready=0 the next cycle.
//    Then cmpl_ready=1 -> issue_ready=1 the cycle after the total drops to 7.
//  4 B id=9 with nothing outstanding -> beat forwarded, err_flag=1, err_id=9, total unchanged.
//    A later SLVERR on id=2 -> err_id stays 9. err_clr -> err_flag=0.
//  5 Same-cycle issue id=4 and B id=4, with cnt[4]=1 -> cnt[4]=1, total unchanged, no error.
//  6 Assert reset with 3 outstanding and cmpl_valid=1 -> all outputs return to reset values
//    asynchronously, and all_done=1.

Source files
------------

// File: rtl/wr_resp_collect_pkg.sv
// Shared AXI header for the cache memory port: ID width, B-channel response codes
// and the ID type used by the B-channel collector.
package wr_resp_collect_pkg;

    localparam int ADD_ID_WIDTH = 4;
    localparam int NUM_IDS      = 1 << ADD_ID_WIDTH;

    typedef logic [ADD_ID_WIDTH-1:0] axi_id_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } bresp_e;

    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/wr_resp_collect_if.sv
// Signal bundle between the cache write path and the B-channel collector:
// AW issue notification, AXI B channel and the completion output register.
interface wr_resp_collect_if;
    import wr_resp_collect_pkg::*;

    logic       aw_issue_valid;
    axi_id_t    aw_issue_id;
    logic       issue_ready;
    axi_id_t    bid;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    logic       cmpl_valid;
    axi_id_t    cmpl_id;
    logic [1:0] cmpl_resp;
    logic       cmpl_ready;

    // master: the cache / memory side driving issues, B beats and completion ready
    modport master (
        output aw_issue_valid, aw_issue_id, bid, bresp, bvalid, cmpl_ready,
        input  issue_ready, bready, cmpl_valid, cmpl_id, cmpl_resp
    );

    // slave: the collector itself
    modport slave (
        input  aw_issue_valid, aw_issue_id, bid, bresp, bvalid, cmpl_ready,
        output issue_ready, bready, cmpl_valid, cmpl_id, cmpl_resp
    );

endinterface

// File: rtl/wr_outst_cnt.sv
// Per-ID outstanding write counters plus a running total. inc must only be
// asserted while full is 0, which keeps every counter within MAX_OUTST.
module wr_outst_cnt
    import wr_resp_collect_pkg::*;
#(
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  axi_id_t            inc_id,
    input  logic               dec,
    input  axi_id_t            dec_id,
    output logic [NUM_IDS-1:0] cnt_zero,
    output logic               full,
    output logic               empty
);

    logic [CNT_W-1:0] cnt [NUM_IDS];
    logic [CNT_W-1:0] total;

    // An inc and a dec landing on the same ID cancel out for that ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt[i] <= '0;
            end
            total <= '0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (inc && (inc_id == axi_id_t'(i)) && !(dec && (dec_id == axi_id_t'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec && (dec_id == axi_id_t'(i)) && !(inc && (inc_id == axi_id_t'(i)))) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (inc && !dec) begin
                total <= total + 1'b1;
            end else if (dec && !inc) begin
                total <= total - 1'b1;
            end
        end
    end

    always_comb begin
        cnt_zero = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            cnt_zero[i] = (cnt[i] == '0);
        end
    end

    assign full  = (total == CNT_W'(MAX_OUTST));
    assign empty = (total == '0);

endmodule

// File: rtl/wr_resp_collect.sv
// AXI B-channel receiver for the cache memory port: tracks outstanding writes per ID,
// forwards each response through a 1-entry completion register and flags bad responses.
module wr_resp_collect
    import wr_resp_collect_pkg::*;
#(
    parameter int MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              reset,
    wr_resp_collect_if.slave  bus,
    output logic              all_done,
    output logic              err_flag,
    output axi_id_t           err_id,
    input  logic              err_clr
);

    logic               rst_done;
    logic               issue_ready;
    logic               bready;
    logic               issue_ok;
    logic               hs;
    logic               same_id_issue;
    logic               unexpected;
    logic               dec;
    logic               new_err;
    logic               full;
    logic               empty;
    logic [NUM_IDS-1:0] cnt_zero;
    logic               cmpl_valid_q;
    axi_id_t            cmpl_id_q;
    logic [1:0]         cmpl_resp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Valid/ready: a beat transfers on any clock where valid & ready are both 1; valid
    // never waits on ready, and bready passes cmpl_ready through so the register
    // can be refilled in the same clock it is drained.
    assign issue_ready   = rst_done & ~full;
    assign bready        = rst_done & (~cmpl_valid_q | bus.cmpl_ready);
    assign hs            = bus.bvalid & bready;
    assign issue_ok      = bus.aw_issue_valid & issue_ready;
    assign same_id_issue = issue_ok & (bus.aw_issue_id == bus.bid);
    assign unexpected    = hs & cnt_zero[bus.bid] & ~same_id_issue;
    assign dec           = hs & ~unexpected;
    assign new_err       = unexpected | (hs & is_err_resp(bus.bresp));

    wr_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (issue_ok),
        .inc_id   (bus.aw_issue_id),
        .dec      (dec),
        .dec_id   (bus.bid),
        .cnt_zero (cnt_zero),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmpl_valid_q <= 1'b0;
            cmpl_id_q    <= '0;
            cmpl_resp_q  <= '0;
        end else if (hs) begin
            cmpl_valid_q <= 1'b1;
            cmpl_id_q    <= bus.bid;
            cmpl_resp_q  <= bus.bresp;
        end else if (bus.cmpl_ready) begin
            cmpl_valid_q <= 1'b0;
        end
    end

    // First error wins; a clear in the same clock as a new error re-arms on the new ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_id   <= '0;
        end else if (new_err) begin
            err_flag <= 1'b1;
            if (!err_flag || err_clr) begin
                err_id <= bus.bid;
            end
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_id   <= '0;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.bready      = bready;
    assign bus.cmpl_valid  = cmpl_valid_q;
    assign bus.cmpl_id     = cmpl_id_q;
    assign bus.cmpl_resp   = cmpl_resp_q;
    assign all_done        = empty;

endmodule

// File: tb/tb_wr_resp_collect.sv
// Bench for wr_resp_collect: directed vector table, randomized traffic against a
// queue/array reference model, and an asynchronous reset in mid-operation.
module tb_wr_resp_collect;
    import wr_resp_collect_pkg::*;

    localparam int MAXO = 8;
    localparam int EW   = ADD_ID_WIDTH + 2;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    err_clr = 1'b0;
    logic    all_done;
    logic    err_flag;
    axi_id_t err_id;

    wr_resp_collect_if bif();

    wr_resp_collect #(.MAX_OUTST(MAXO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif.slave),
        .all_done (all_done),
        .err_flag (err_flag),
        .err_id   (err_id),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    bit            m_rst_done;
    int            m_cnt [NUM_IDS];
    int            m_total;
    logic [EW-1:0] exp_q [$];
    bit            m_ef;
    int            m_eid;

    typedef struct {
        bit awv; int awid; bit bv; int bid; int br; bit cr; bit ec;
        bit e_ir; bit e_br; bit e_cv; int e_cid; bit e_ad; bit e_ef; int e_eid;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit awv, input int awid, input bit bv, input int bid,
                         input int br, input bit cr, input bit ec);
        bif.aw_issue_valid = awv;
        bif.aw_issue_id    = axi_id_t'(awid);
        bif.bvalid         = bv;
        bif.bid            = axi_id_t'(bid);
        bif.bresp          = 2'(br);
        bif.cmpl_ready     = cr;
        err_clr            = ec;
    endtask

    task automatic add(input bit awv, input int awid, input bit bv, input int bid, input int br,
                       input bit cr, input bit ec, input bit e_ir, input bit e_br, input bit e_cv,
                       input int e_cid, input bit e_ad, input bit e_ef, input int e_eid);
        vec_t v;
        v = '{awv, awid, bv, bid, br, cr, ec, e_ir, e_br, e_cv, e_cid, e_ad, e_ef, e_eid};
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_rst_done = 0;
        for (int i = 0; i < NUM_IDS; i++) m_cnt[i] = 0;
        m_total = 0;
        exp_q.delete();
        m_ef = 0;
        m_eid = 0;
    endtask

    // Compare outputs for the current inputs, then advance the model across the next edge.
    task automatic model_cycle();
        bit ir, br, cv, issue, hs, known, newerr;
        logic [EW-1:0] head;
        ir = m_rst_done && (m_total < MAXO);
        br = m_rst_done && (exp_q.size() == 0 || bif.cmpl_ready);
        cv = (exp_q.size() != 0);
        chk("m_issue_ready", bif.issue_ready, ir);
        chk("m_bready", bif.bready, br);
        chk("m_cmpl_valid", bif.cmpl_valid, cv);
        if (cv) begin
            head = exp_q[0];
            chk("m_cmpl_id", bif.cmpl_id, head[EW-1:2]);
            chk("m_cmpl_resp", bif.cmpl_resp, head[1:0]);
        end
        chk("m_all_done", all_done, m_total == 0);
        chk("m_err_flag", err_flag, m_ef);
        chk("m_err_id", err_id, m_eid);

        issue = bif.aw_issue_valid && ir;
        hs    = bif.bvalid && br;
        known = (m_cnt[bif.bid] > 0) || (issue && bif.aw_issue_id == bif.bid);
        if (cv && bif.cmpl_ready) void'(exp_q.pop_front());
        if (hs) exp_q.push_back({bif.bid, bif.bresp});
        if (issue) begin
            m_cnt[bif.aw_issue_id]++;
            m_total++;
        end
        if (hs && known) begin
            m_cnt[bif.bid]--;
            m_total--;
        end
        newerr = hs && (!known || bif.bresp >= 2);
        if (newerr) begin
            if (!m_ef || err_clr) m_eid = bif.bid;
            m_ef = 1;
        end else if (err_clr) begin
            m_ef = 0;
            m_eid = 0;
        end
        m_rst_done = 1;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_issue_ready"}, bif.issue_ready, 0);
        chk({tag, "_bready"}, bif.bready, 0);
        chk({tag, "_cmpl_valid"}, bif.cmpl_valid, 0);
        chk({tag, "_cmpl_id"}, bif.cmpl_id, 0);
        chk({tag, "_cmpl_resp"}, bif.cmpl_resp, 0);
        chk({tag, "_all_done"}, all_done, 1);
        chk({tag, "_err_flag"}, err_flag, 0);
        chk({tag, "_err_id"}, err_id, 0);
    endtask

    initial begin
        // test 2: three issues, out-of-order responses
        add(1,3,0,0,0,1,0, 1,1,0,0,1,0,0);
        add(1,3,0,0,0,1,0, 1,1,0,0,0,0,0);
        add(1,5,0,0,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,1,5,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,1,3,0,1,0, 1,1,1,5,0,0,0);
        add(0,0,1,3,0,1,0, 1,1,1,3,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,3,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,0);
        // test 3: fill to MAX_OUTST, stall completion, then drain
        for (int k = 0; k < 8; k++) add(1,k,0,0,0,1,0, 1,1,0,0,(k == 0),0,0);
        add(0,0,1,0,0,0,0, 0,1,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,0,1,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,0,0,0,0,0);
        for (int k = 1; k < 8; k++) add(0,0,1,k,0,1,0, 1,1,(k > 1),k-1,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,7,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,0);
        // test 4: unexpected ID, later SLVERR, clear
        add(0,0,1,9,0,1,0, 1,1,0,0,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,9,1,1,9);
        add(1,2,0,0,0,1,0, 1,1,0,0,1,1,9);
        add(0,0,1,2,2,1,0, 1,1,0,0,0,1,9);
        add(0,0,0,0,0,1,0, 1,1,1,2,1,1,9);
        add(0,0,0,0,0,1,1, 1,1,0,0,1,1,9);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,0);
        // clear colliding with a new error
        add(0,0,1,11,0,1,1, 1,1,0,0,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,11,1,1,11);
        add(0,0,1,12,3,1,1, 1,1,0,0,1,1,11);
        add(0,0,0,0,0,1,0, 1,1,1,12,1,1,12);
        add(0,0,0,0,0,1,1, 1,1,0,0,1,1,12);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,0);
        // test 5: same-cycle issue/response, same and different IDs
        add(1,4,0,0,0,1,0, 1,1,0,0,1,0,0);
        add(1,4,1,4,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,4,0,0,0);
        add(0,0,1,4,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,4,1,0,0);
        add(1,6,1,6,1,1,0, 1,1,0,0,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,6,1,0,0);
        add(1,1,0,0,0,1,0, 1,1,0,0,1,0,0);
        add(1,2,1,1,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,1,0,0,0);
        add(0,0,1,2,0,1,0, 1,1,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,2,1,0,0);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,0);

        // test 1: reset values, then rst_done release
        drive(0,0,0,0,0,0,0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rel_issue_ready", bif.issue_ready, 0);
        chk("rel_bready", bif.bready, 0);
        model_cycle();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_issue_ready", bif.issue_ready, 1);
        chk("idle_bready", bif.bready, 1);
        chk("idle_all_done", all_done, 1);
        model_cycle();
        @(posedge clk);
        #1;

        // directed table
        foreach (vecs[i]) begin
            drive(vecs[i].awv, vecs[i].awid, vecs[i].bv, vecs[i].bid, vecs[i].br, vecs[i].cr, vecs[i].ec);
            @(negedge clk);
            chk($sformatf("t%0d_issue_ready", i), bif.issue_ready, vecs[i].e_ir);
            chk($sformatf("t%0d_bready", i), bif.bready, vecs[i].e_br);
            chk($sformatf("t%0d_cmpl_valid", i), bif.cmpl_valid, vecs[i].e_cv);
            if (vecs[i].e_cv) chk($sformatf("t%0d_cmpl_id", i), bif.cmpl_id, vecs[i].e_cid);
            chk($sformatf("t%0d_all_done", i), all_done, vecs[i].e_ad);
            chk($sformatf("t%0d_err_flag", i), err_flag, vecs[i].e_ef);
            chk($sformatf("t%0d_err_id", i), err_id, vecs[i].e_eid);
            model_cycle();
            @(posedge clk);
            #1;
        end

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            bit awv, bv, found;
            int bid, start;
            awv = m_rst_done && (m_total < MAXO) && ($urandom_range(0, 2) == 0);
            bv = ($urandom_range(0, 1) == 1);
            bid = $urandom_range(0, NUM_IDS - 1);
            found = 0;
            if (m_total > 0 && $urandom_range(0, 9) != 0) begin
                start = $urandom_range(0, NUM_IDS - 1);
                for (int j = 0; j < NUM_IDS; j++) begin
                    if (!found && m_cnt[(start + j) % NUM_IDS] > 0) begin
                        bid = (start + j) % NUM_IDS;
                        found = 1;
                    end
                end
            end
            drive(awv, $urandom_range(0, 7), bv, bid,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            step();
        end

        // test 6: asynchronous reset with writes outstanding and a completion pending
        drive(0,0,0,0,0,1,0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        drive(1,1,0,0,0,1,0); step();
        drive(1,2,0,0,0,1,0); step();
        drive(1,3,1,13,0,1,0); step();
        drive(0,0,0,0,0,0,0);
        @(negedge clk);
        chk("pre_rst_cmpl_valid", bif.cmpl_valid, 1);
        chk("pre_rst_all_done", all_done, 0);
        model_cycle();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        step();
        drive(1,5,0,0,0,1,0); step();
        drive(0,0,1,5,0,1,0); step();
        drive(0,0,0,0,0,1,0); step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
